// File: rtl/priority_mux_arbiter_if.sv
// Request/grant bundle between the requesters and the mux-chain arbiter.
interface priority_mux_arbiter_if;
  logic [5:0] req;
  logic       done;
  logic       mode;
  logic [5:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic [4:0] sel;

  // requester side
  modport master (
    output req, done, mode,
    input  gnt, gnt_id, gnt_valid, sel
  );

  // arbiter side
  modport slave (
    input  req, done, mode,
    output gnt, gnt_id, gnt_valid, sel
  );
endinterface

// File: rtl/priority_mux_arbiter.sv
// Six-way arbiter in front of the priority mux chain. Registers a one-hot
// grant and the matching s0..s4 select pattern; fixed-priority or
// round-robin selection with a per-grant hold limit.
//
// state   | meaning
// --------+------------------------------------------
// S_IDLE  | no owner, outputs cleared
// S_GRANT | one owner, gnt/sel/gnt_valid driven
module priority_mux_arbiter #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  priority_mux_arbiter_if.slave  bus
);

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  localparam logic [3:0] LP_HOLD = 4'(MAX_HOLD);

  state_t     r_state;
  logic [2:0] r_owner;
  logic [2:0] r_last;
  logic [3:0] r_cnt;
  logic [5:0] r_gnt;
  logic [4:0] r_sel;
  logic       r_valid;

  state_t     w_nxt_state;
  logic [2:0] w_nxt_owner;
  logic [2:0] w_nxt_last;
  logic [3:0] w_nxt_cnt;
  logic [5:0] w_nxt_gnt;
  logic [4:0] w_nxt_sel;
  logic       w_nxt_valid;

  logic [5:0] w_owner_bit;
  logic       w_hold_hit;
  logic       w_req_drop;
  logic       w_release;
  logic       w_mask_owner;
  logic [5:0] w_elig;
  logic [2:0] w_pick;

  // Highest set bit wins, matching the chain's own priority order.
  function automatic logic [2:0] f_pick_fixed(input logic [5:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (v[3'(i)]) idx = 3'(i);
    end
    return idx;
  endfunction

  // First set bit after the previous owner, wrapping 5 -> 0; the previous
  // owner itself is checked last.
  function automatic logic [2:0] f_pick_rr(input logic [5:0] v, input logic [2:0] last);
    logic [2:0] idx;
    logic [2:0] pos;
    logic       found;
    idx   = 3'd0;
    found = 1'b0;
    for (int step = 1; step <= 6; step++) begin
      pos = 3'((int'(last) + step) % 6);
      if (!found && v[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  assign w_owner_bit  = 6'(1) << r_owner;
  assign w_hold_hit   = (MAX_HOLD != 0) && (r_cnt == LP_HOLD);
  assign w_req_drop   = !bus.req[r_owner];
  assign w_release    = (r_state == S_GRANT) && (bus.done || w_req_drop || w_hold_hit);
  // done and hold-limit releases both exclude the outgoing owner from this decision
  assign w_mask_owner = (r_state == S_GRANT) && (bus.done || w_hold_hit);
  assign w_elig       = w_mask_owner ? (bus.req & ~w_owner_bit) : bus.req;
  assign w_pick       = bus.mode ? f_pick_rr(w_elig, r_last) : f_pick_fixed(w_elig);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_owner <= 3'd0;
      r_last  <= 3'd5;
      r_cnt   <= 4'd0;
      r_gnt   <= 6'd0;
      r_sel   <= 5'd0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_owner <= w_nxt_owner;
      r_last  <= w_nxt_last;
      r_cnt   <= w_nxt_cnt;
      r_gnt   <= w_nxt_gnt;
      r_sel   <= w_nxt_sel;
      r_valid <= w_nxt_valid;
    end
  end

  // Next-state: arbitration decision, ownership, hold counter.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_owner = r_owner;
    w_nxt_last  = r_last;
    w_nxt_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.req != 6'd0) begin
          w_nxt_state = S_GRANT;
          w_nxt_owner = w_pick;
          w_nxt_last  = w_pick;
          w_nxt_cnt   = 4'd1;
        end
      end
      S_GRANT: begin
        if (!w_release) begin
          w_nxt_cnt = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
        end else if (w_elig != 6'd0) begin
          w_nxt_owner = w_pick;
          w_nxt_last  = w_pick;
          w_nxt_cnt   = 4'd1;
        end else if (w_hold_hit && !bus.done && !w_req_drop) begin
          // nobody else wants the chain: keep the owner, restart its window
          w_nxt_last = r_owner;
          w_nxt_cnt  = 4'd1;
        end else begin
          w_nxt_state = S_IDLE;
          w_nxt_owner = 3'd0;
          w_nxt_cnt   = 4'd0;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_owner = 3'd0;
        w_nxt_cnt   = 4'd0;
      end
    endcase
  end

  // Output decode of the next owner into grant and select patterns.
  always_comb begin
    w_nxt_valid = (w_nxt_state == S_GRANT);
    w_nxt_gnt   = 6'd0;
    w_nxt_sel   = 5'd0;
    if (w_nxt_valid) begin
      w_nxt_gnt = 6'(1) << w_nxt_owner;
      if (w_nxt_owner != 3'd0) w_nxt_sel = 5'(1) << (w_nxt_owner - 3'd1);
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_id    = r_owner;
  assign bus.gnt_valid = r_valid;
  assign bus.sel       = r_sel;

endmodule

// File: tb/tb_priority_mux_arbiter.sv
// Directed bench for priority_mux_arbiter (MAX_HOLD = 4).
module tb_priority_mux_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  priority_mux_arbiter_if bus();

  priority_mux_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [5:0] req;
    logic       done;
    logic       mode;
    logic [5:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic [4:0] sel;
  } vec_t;

  vec_t tbl[14];

  task automatic drive(input logic r, input logic [5:0] q, input logic d, input logic m);
    rst_n    = r;
    bus.req  = q;
    bus.done = d;
    bus.mode = m;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [5:0] g, input logic [2:0] id,
                     input logic v, input logic [4:0] s);
    checks++;
    if (bus.gnt !== g || bus.gnt_id !== id || bus.gnt_valid !== v || bus.sel !== s) begin
      errors++;
      $display("FAIL %s: got gnt=%b id=%0d valid=%b sel=%b, want gnt=%b id=%0d valid=%b sel=%b",
               name, bus.gnt, bus.gnt_id, bus.gnt_valid, bus.sel, g, id, v, s);
    end
  endtask

  task automatic chk_owner(input string name, input int o);
    logic [4:0] s;
    s = (o == 0) ? 5'd0 : (5'(1) << (o - 1));
    chk(name, 6'(1) << o, 3'(o), 1'b1, s);
  endtask

  task automatic do_reset();
    drive(1'b0, 6'd0, 1'b0, 1'b0);
    step();
    chk("reset", 6'd0, 3'd0, 1'b0, 5'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b0, 6'd0, 1'b0, 1'b0);

    //            rst   req     done  mode  gnt      id    v     sel
    tbl[0]  = '{1'b0, 6'h3F, 1'b0, 1'b0, 6'h00, 3'd0, 1'b0, 5'b00000};
    tbl[1]  = '{1'b0, 6'h3F, 1'b0, 1'b0, 6'h00, 3'd0, 1'b0, 5'b00000};
    tbl[2]  = '{1'b1, 6'h3F, 1'b0, 1'b0, 6'h20, 3'd5, 1'b1, 5'b10000};
    tbl[3]  = '{1'b1, 6'h06, 1'b0, 1'b0, 6'h04, 3'd2, 1'b1, 5'b00010};
    tbl[4]  = '{1'b1, 6'h06, 1'b1, 1'b0, 6'h02, 3'd1, 1'b1, 5'b00001};
    tbl[5]  = '{1'b1, 6'h06, 1'b0, 1'b0, 6'h02, 3'd1, 1'b1, 5'b00001};
    tbl[6]  = '{1'b1, 6'h00, 1'b0, 1'b0, 6'h00, 3'd0, 1'b0, 5'b00000};
    tbl[7]  = '{1'b1, 6'h08, 1'b0, 1'b1, 6'h08, 3'd3, 1'b1, 5'b00100};
    tbl[8]  = '{1'b1, 6'h00, 1'b0, 1'b1, 6'h00, 3'd0, 1'b0, 5'b00000};
    tbl[9]  = '{1'b1, 6'h01, 1'b1, 1'b0, 6'h01, 3'd0, 1'b1, 5'b00000};
    tbl[10] = '{1'b1, 6'h21, 1'b0, 1'b1, 6'h01, 3'd0, 1'b1, 5'b00000};
    tbl[11] = '{1'b1, 6'h21, 1'b0, 1'b0, 6'h01, 3'd0, 1'b1, 5'b00000};
    tbl[12] = '{1'b1, 6'h21, 1'b0, 1'b0, 6'h01, 3'd0, 1'b1, 5'b00000};
    tbl[13] = '{1'b1, 6'h21, 1'b0, 1'b0, 6'h20, 3'd5, 1'b1, 5'b10000};

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst_n, tbl[i].req, tbl[i].done, tbl[i].mode);
      step();
      chk($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].id, tbl[i].valid, tbl[i].sel);
    end

    // round-robin, done on the third cycle of each grant
    do_reset();
    drive(1'b1, 6'h3F, 1'b0, 1'b1);
    step();
    chk_owner("rr_first", 0);
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 3; j++) begin
        bus.done = (j == 2);
        step();
        chk_owner($sformatf("rr_k%0d_j%0d", k, j), (j == 2) ? (k + 1) % 6 : k);
      end
    end
    bus.done = 1'b0;

    // hold limit alternates two requesters every 4 cycles
    do_reset();
    drive(1'b1, 6'h21, 1'b0, 1'b0);
    for (int c = 0; c < 16; c++) begin
      step();
      chk_owner($sformatf("hold_alt%0d", c), ((c / 4) % 2 == 0) ? 5 : 0);
    end

    // lone requester is re-granted without a gap
    do_reset();
    drive(1'b1, 6'h20, 1'b0, 1'b0);
    for (int c = 0; c < 12; c++) begin
      step();
      chk_owner($sformatf("hold_solo%0d", c), 5);
    end

    // done coinciding with hold expiry behaves as done: idle when alone
    do_reset();
    drive(1'b1, 6'h20, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) step();
    chk_owner("hold_pre_done", 5);
    bus.done = 1'b1;
    step();
    chk("done_at_hold", 6'd0, 3'd0, 1'b0, 5'd0);
    bus.done = 1'b0;

    // reset in the middle of a grant, round-robin pointer restored
    do_reset();
    drive(1'b1, 6'h10, 1'b0, 1'b1);
    step();
    chk_owner("mid_grant1", 4);
    step();
    chk_owner("mid_grant2", 4);
    rst_n = 1'b0;
    step();
    chk("mid_reset", 6'd0, 3'd0, 1'b0, 5'd0);
    drive(1'b1, 6'h3F, 1'b0, 1'b1);
    step();
    chk_owner("rr_after_reset", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
